// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Producer side of the register-file write port. It merges two result streams
// into a single registered write per cycle:
//   - load results from data memory (never stalled, highest priority), with
//     RISC-V byte/halfword extraction and sign/zero extension applied first;
//   - ALU results (valid/ready handshake), held in a small circular FIFO
//     whenever they cannot be written straight away.
//
// Optional feature: define WB_STALL_COUNT_EN to build the saturating
// stall_cycles counter. When it is undefined, stall_cycles is tied to zero and
// the port list does not change.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   alu_valid/alu_ready   ALU result handshake
//   alu_rd, alu_data      ALU destination register and result
//   mem_valid             load result present this cycle (always consumed)
//   mem_rd, mem_data      load destination and raw aligned memory word
//   mem_funct3            load type (lb/lh/lw/lbu/lhu)
//   mem_byte_off          load address[1:0]
//   write_enable          register-file write strobe (registered)
//   addr_rd, data_rd      register-file write address and data (registered)
//   alu_pending           ALU FIFO occupancy
//   stall_cycles          count of cycles with alu_valid && !alu_ready
// -----------------------------------------------------------------------------
module writeback_unit #(
   parameter int DATAW          = 32,
   parameter int ADDRW          = 5,
   parameter int ALU_FIFO_DEPTH = 2
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              alu_valid,
   output logic                              alu_ready,
   input  logic [ADDRW-1:0]                  alu_rd,
   input  logic [DATAW-1:0]                  alu_data,
   input  logic                              mem_valid,
   input  logic [ADDRW-1:0]                  mem_rd,
   input  logic [DATAW-1:0]                  mem_data,
   input  logic [2:0]                        mem_funct3,
   input  logic [1:0]                        mem_byte_off,
   output logic                              write_enable,
   output logic [ADDRW-1:0]                  addr_rd,
   output logic [DATAW-1:0]                  data_rd,
   output logic [$clog2(ALU_FIFO_DEPTH):0]   alu_pending,
   output logic [31:0]                       stall_cycles
);

   localparam int PW = $clog2(ALU_FIFO_DEPTH);
   localparam logic [PW:0] FULL_COUNT = ALU_FIFO_DEPTH[PW:0];

   // Byte/halfword extraction with sign or zero extension. Reserved funct3
   // encodings fall through to a full-word load.
   function automatic logic [DATAW-1:0] load_extract(
      input logic [DATAW-1:0] word,
      input logic [2:0]       funct3,
      input logic [1:0]       off
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [DATAW-1:0] res;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = word[7:0];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (funct3)
         3'b000:  res = {{(DATAW-8){b[7]}}, b};
         3'b001:  res = {{(DATAW-16){h[15]}}, h};
         3'b100:  res = {{(DATAW-8){1'b0}}, b};
         3'b101:  res = {{(DATAW-16){1'b0}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   logic [ADDRW-1:0] r_fifo_rd   [ALU_FIFO_DEPTH];
   logic [DATAW-1:0] r_fifo_data [ALU_FIFO_DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;

   logic             r_write_enable;
   logic [ADDRW-1:0] r_addr_rd;
   logic [DATAW-1:0] r_data_rd;

   logic             w_full;
   logic             w_not_empty;
   logic             w_alu_ready;
   logic             w_alu_hs;
   logic             w_push;
   logic             w_pop;
   logic             w_sel_valid;
   logic [ADDRW-1:0] w_sel_rd;
   logic [DATAW-1:0] w_sel_data;
   logic [DATAW-1:0] w_load_data;

   assign w_full      = (r_count == FULL_COUNT);
   assign w_not_empty = (r_count != {(PW+1){1'b0}});
   // A full FIFO refuses a push even if it pops in the same cycle.
   assign w_alu_ready = !w_full && !reset;
   assign w_alu_hs    = alu_valid && w_alu_ready;
   assign w_load_data = load_extract(mem_data, mem_funct3, mem_byte_off);

   // Source selection: load, then FIFO head, then ALU bypass.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_rd    = r_addr_rd;
      w_sel_data  = r_data_rd;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      if (mem_valid) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = mem_rd;
         w_sel_data  = w_load_data;
         w_push      = w_alu_hs;
      end else if (w_not_empty) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = r_fifo_rd[r_rd_ptr];
         w_sel_data  = r_fifo_data[r_rd_ptr];
         w_pop       = 1'b1;
         w_push      = w_alu_hs;
      end else if (w_alu_hs) begin
         w_sel_valid = 1'b1;
         w_sel_rd    = alu_rd;
         w_sel_data  = alu_data;
      end else begin
         w_sel_valid = 1'b0;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {(PW+1){1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      end
   end

   // FIFO storage; contents are don't-care until pushed, so no reset needed.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= alu_rd;
         r_fifo_data[r_wr_ptr] <= alu_data;
      end
   end

   // Output register; writes to x0 are consumed but never strobed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_write_enable <= 1'b0;
         r_addr_rd      <= {ADDRW{1'b0}};
         r_data_rd      <= {DATAW{1'b0}};
      end else begin
         r_write_enable <= w_sel_valid && (w_sel_rd != {ADDRW{1'b0}});
         if (w_sel_valid) begin
            r_addr_rd <= w_sel_rd;
            r_data_rd <= w_sel_data;
         end
      end
   end

`ifdef WB_STALL_COUNT_EN
   logic [31:0] r_stall_cycles;

   // Saturating count of cycles in which an offered ALU result was refused.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= 32'd0;
      end else if (alu_valid && !w_alu_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`else
   assign stall_cycles = 32'd0;
`endif

   assign alu_ready    = w_alu_ready;
   assign write_enable = r_write_enable;
   assign addr_rd      = r_addr_rd;
   assign data_rd      = r_data_rd;
   assign alu_pending  = r_count;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

   logic        clock;
   logic        reset;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_byte_off;
   logic        write_enable;
   logic [4:0]  addr_rd;
   logic [31:0] data_rd;
   logic [1:0]  alu_pending;
   logic [31:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   writeback_unit dut (
      .clock        (clock),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .mem_funct3   (mem_funct3),
      .mem_byte_off (mem_byte_off),
      .write_enable (write_enable),
      .addr_rd      (addr_rd),
      .data_rd      (data_rd),
      .alu_pending  (alu_pending),
      .stall_cycles (stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        mv;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] md;
      logic [4:0]  mrd;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        exp_we;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic idle();
      alu_valid    = 1'b0;
      alu_rd       = 5'd0;
      alu_data     = 32'd0;
      mem_valid    = 1'b0;
      mem_rd       = 5'd0;
      mem_data     = 32'd0;
      mem_funct3   = 3'b010;
      mem_byte_off = 2'd0;
   endtask

   task automatic drive_mem(input logic [4:0] rd, input logic [31:0] d);
      mem_valid  = 1'b1;
      mem_rd     = rd;
      mem_data   = d;
      mem_funct3 = 3'b010;
   endtask

   task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      alu_valid = v;
      alu_rd    = rd;
      alu_data  = d;
   endtask

   task automatic check_out(input string name, input logic we, input logic [4:0] a, input logic [31:0] d);
      check({name, "_we"}, {31'd0, write_enable}, {31'd0, we});
      if (we) begin
         check({name, "_addr"}, {27'd0, addr_rd}, {27'd0, a});
         check({name, "_data"}, data_rd, d);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      idle();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   localparam logic [31:0] W = 32'h80FF7F01;

   initial begin
      //       mv   f3      off  md     mrd    av    ard   ad             we    addr   data
      vecs[0]  = '{1'b0, 3'b010, 2'd0, 32'd0, 5'd0,  1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5,  32'h12345678};
      vecs[1]  = '{1'b1, 3'b000, 2'd2, W,     5'd10, 1'b0, 5'd0, 32'd0,        1'b1, 5'd10, 32'hFFFFFFFF};
      vecs[2]  = '{1'b1, 3'b100, 2'd3, W,     5'd11, 1'b0, 5'd0, 32'd0,        1'b1, 5'd11, 32'h00000080};
      vecs[3]  = '{1'b1, 3'b001, 2'd2, W,     5'd12, 1'b0, 5'd0, 32'd0,        1'b1, 5'd12, 32'hFFFF80FF};
      vecs[4]  = '{1'b1, 3'b101, 2'd0, W,     5'd13, 1'b0, 5'd0, 32'd0,        1'b1, 5'd13, 32'h00007F01};
      vecs[5]  = '{1'b1, 3'b010, 2'd1, W,     5'd14, 1'b0, 5'd0, 32'd0,        1'b1, 5'd14, 32'h80FF7F01};
      vecs[6]  = '{1'b1, 3'b011, 2'd2, W,     5'd15, 1'b0, 5'd0, 32'd0,        1'b1, 5'd15, 32'h80FF7F01};
      vecs[7]  = '{1'b1, 3'b000, 2'd0, W,     5'd16, 1'b0, 5'd0, 32'd0,        1'b1, 5'd16, 32'h00000001};
      vecs[8]  = '{1'b1, 3'b101, 2'd3, W,     5'd17, 1'b0, 5'd0, 32'd0,        1'b1, 5'd17, 32'h000080FF};
      vecs[9]  = '{1'b0, 3'b010, 2'd0, 32'd0, 5'd0,  1'b0, 5'd0, 32'd0,        1'b0, 5'd17, 32'h000080FF};
      vecs[10] = '{1'b1, 3'b001, 2'd0, W,     5'd18, 1'b0, 5'd0, 32'd0,        1'b1, 5'd18, 32'h00007F01};
      vecs[11] = '{1'b1, 3'b100, 2'd1, W,     5'd19, 1'b0, 5'd0, 32'd0,        1'b1, 5'd19, 32'h0000007F};

      idle();
      reset = 1'b1;
      #1;
      check("rst_ready", {31'd0, alu_ready}, 32'd0);
      check("rst_we", {31'd0, write_enable}, 32'd0);
      check("rst_addr", {27'd0, addr_rd}, 32'd0);
      check("rst_data", data_rd, 32'd0);
      check("rst_pending", {30'd0, alu_pending}, 32'd0);
      check("rst_stall", stall_cycles, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;

      // Single-cycle vectors, FIFO empty throughout.
      for (int i = 0; i < 12; i++) begin
         mem_valid    = vecs[i].mv;
         mem_funct3   = vecs[i].f3;
         mem_byte_off = vecs[i].off;
         mem_data     = vecs[i].md;
         mem_rd       = vecs[i].mrd;
         alu_valid    = vecs[i].av;
         alu_rd       = vecs[i].ard;
         alu_data     = vecs[i].ad;
         #1;
         check($sformatf("v%0d_ready", i), {31'd0, alu_ready}, 32'd1);
         @(negedge clock);
         check($sformatf("v%0d_we", i), {31'd0, write_enable}, {31'd0, vecs[i].exp_we});
         check($sformatf("v%0d_addr", i), {27'd0, addr_rd}, {27'd0, vecs[i].exp_addr});
         check($sformatf("v%0d_data", i), data_rd, vecs[i].exp_data);
         check($sformatf("v%0d_pending", i), {30'd0, alu_pending}, 32'd0);
      end
      idle();

      // rd=0 ALU result is consumed without a write; following rd=7 result follows.
      @(negedge clock);
      drive_alu(1'b1, 5'd0, 32'h000000AA);
      #1;
      check("x0_ready", {31'd0, alu_ready}, 32'd1);
      @(negedge clock);
      check("x0_we", {31'd0, write_enable}, 32'd0);
      check("x0_pending", {30'd0, alu_pending}, 32'd0);
      drive_alu(1'b1, 5'd7, 32'h00000077);
      @(negedge clock);
      check_out("x7", 1'b1, 5'd7, 32'h00000077);
      idle();

      // Loads held three cycles while ALU offers rd 1,2,3.
      pulse_reset();
      drive_mem(5'd20, 32'hA0);
      drive_alu(1'b1, 5'd1, 32'h11);
      #1;
      check("pri_c0_ready", {31'd0, alu_ready}, 32'd1);
      @(negedge clock);
      check_out("pri_c1", 1'b1, 5'd20, 32'hA0);
      check("pri_c1_pend", {30'd0, alu_pending}, 32'd1);
      drive_mem(5'd21, 32'hA1);
      drive_alu(1'b1, 5'd2, 32'h22);
      @(negedge clock);
      check_out("pri_c2", 1'b1, 5'd21, 32'hA1);
      check("pri_c2_pend", {30'd0, alu_pending}, 32'd2);
      drive_mem(5'd22, 32'hA2);
      drive_alu(1'b1, 5'd3, 32'h33);
      #1;
      check("pri_full_ready", {31'd0, alu_ready}, 32'd0);
      @(negedge clock);
      check_out("pri_c3", 1'b1, 5'd22, 32'hA2);
      check("pri_c3_pend", {30'd0, alu_pending}, 32'd2);
      mem_valid = 1'b0;
      #1;
      check("pri_popfull_ready", {31'd0, alu_ready}, 32'd0);
      @(negedge clock);
      check_out("pri_c4", 1'b1, 5'd1, 32'h11);
      check("pri_c4_pend", {30'd0, alu_pending}, 32'd1);
      #1;
      check("pri_c4_ready", {31'd0, alu_ready}, 32'd1);
      @(negedge clock);
      check_out("pri_c5", 1'b1, 5'd2, 32'h22);
      check("pri_c5_pend", {30'd0, alu_pending}, 32'd1);
      alu_valid = 1'b0;
      @(negedge clock);
      check_out("pri_c6", 1'b1, 5'd3, 32'h33);
      check("pri_c6_pend", {30'd0, alu_pending}, 32'd0);
      @(negedge clock);
      check("pri_c7_we", {31'd0, write_enable}, 32'd0);
`ifdef WB_STALL_COUNT_EN
      check("pri_stall", stall_cycles, 32'd2);
`else
      check("pri_stall", stall_cycles, 32'd0);
`endif
      idle();

      // Reset mid-operation with two buffered entries.
      @(negedge clock);
      drive_mem(5'd24, 32'hB0);
      drive_alu(1'b1, 5'd25, 32'h55);
      @(negedge clock);
      drive_mem(5'd26, 32'hB1);
      drive_alu(1'b1, 5'd27, 32'h66);
      @(negedge clock);
      check("mid_pend_before", {30'd0, alu_pending}, 32'd2);
      idle();
      reset = 1'b1;
      #1;
      check("mid_pend_rst", {30'd0, alu_pending}, 32'd0);
      check("mid_we_rst", {31'd0, write_enable}, 32'd0);
      check("mid_ready_rst", {31'd0, alu_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check($sformatf("mid_after%0d_we", k), {31'd0, write_enable}, 32'd0);
         check($sformatf("mid_after%0d_pend", k), {30'd0, alu_pending}, 32'd0);
      end

      // Stall counting: fill FIFO under loads, then hold alu_valid 4 cycles.
      pulse_reset();
      check("stall_clr", stall_cycles, 32'd0);
      drive_mem(5'd8, 32'hC0);
      drive_alu(1'b1, 5'd9, 32'h99);
      @(negedge clock);
      drive_alu(1'b1, 5'd10, 32'h9A);
      @(negedge clock);
      check("stall_full", {30'd0, alu_pending}, 32'd2);
      drive_alu(1'b1, 5'd11, 32'h9B);
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("stall_ready%0d", k), {31'd0, alu_ready}, 32'd0);
         @(negedge clock);
      end
      idle();
`ifdef WB_STALL_COUNT_EN
      check("stall_count", stall_cycles, 32'd4);
`else
      check("stall_count", stall_cycles, 32'd0);
`endif
      @(negedge clock);
      check_out("stall_drain0", 1'b1, 5'd9, 32'h99);
      @(negedge clock);
      check_out("stall_drain1", 1'b1, 5'd10, 32'h9A);
      check("stall_drain_pend", {30'd0, alu_pending}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
